aes_decrypt_seq: RTL and testbench
==================================

# aes_decrypt_seq

Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decrypt counterpart of the sequential encryptor. It accepts a 128-bit ciphertext and the original cipher key on a single-cycle `start` pulse. It derives the last round key on the fly, then runs one inverse round per clock while regenerating round keys backwards. The recovered plaintext is presented with a one-cycle `done` pulse. It sits beside the encryptor in the datapath and uses the same byte order: byte 0 is bits [127:120].

## Interface
Parameters: none (AES-128 only, Nr = 10).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `ciphertext` in 128: block to decrypt. Captured on the accepting edge.
- `key` in 128: cipher key, round key 0. Captured on the accepting edge.
- `plaintext` out 128: result. Valid from `done` until the next accepted `start`.
- `done` out 1: one-cycle pulse when `plaintext` is valid.
- `busy` out 1: high from the accepting edge until `done` rises.

## Operation
States: IDLE, KEYX, ADDK, ROUND, FINAL, DONE.
- IDLE/DONE: `start`=1 loads `st`←ciphertext, `rk`←key, `rcon`←0x01, `cnt`←0, clears `plaintext`-valid tracking, then goes to KEYX.
- KEYX, 10 cycles: forward key step `rk`←KeyExp(`rk`,`rcon`), `rcon`←xtime(`rcon`). After the 10th step `rk` = round key 10 and `rcon` is forced to 0x36. Go to ADDK.
- ADDK, 1 cycle: `st`←`st`^`rk`, `rk`←InvKeyStep(`rk`,`rcon`), `rcon`←inv_xtime(`rcon`). Go to ROUND.
- ROUND, 9 cycles for rounds 9..1:
  - `st`←InvMixColumns(InvSubBytes(InvShiftRows(`st`))^`rk`).
  - `rk`←InvKeyStep, `rcon`←inv_xtime.
  - Go to FINAL after the 9th.
- FINAL, 1 cycle: `plaintext`←InvSubBytes(InvShiftRows(`st`))^`rk`, where `rk` = round key 0. Go to DONE.
- DONE: `done`=1 for exactly this cycle. The next edge goes to IDLE unless `start`=1, in which case it goes to KEYX (back-to-back).
- InvKeyStep, from words w0..w3 of round key i to round key i-1:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}.
- inv_xtime(x) = x[0] ? (x^0x11B)>>1 : x>>1. Sequence: 0x36, 0x1B, 0x80, 0x40, … 0x01.
- `start` in KEYX/ADDK/ROUND/FINAL is ignored. It is not queued, and input changes during this time have no effect.
- Reset in any state:
  - Immediately forces IDLE and sets `plaintext`=0, `done`=0, `busy`=0.
  - Clears `st`, `rk`, `rcon`, and `cnt`.
  - The aborted operation produces no `done`.

## Timing
- Accepting edge = E0. `busy` is high after E0.
- Edges E1–E10: KEYX. E11: ADDK. E12–E20: ROUND. E21: FINAL.
- `done`=1 and `busy`=0 in the cycle after E21. Latency is 21 cycles, start-sample to `done`.
- `done` deasserts after one cycle. `plaintext` holds until the next accepting edge, where it is not cleared; it updates only at FINAL.
- Throughput: one block per 22 cycles with back-to-back `start` in DONE.
- Reset values: `plaintext`=128'h0, `done`=0, `busy`=0.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package `aes_pkg`, also used by the encryptor: S-box and inverse S-box functions, `xtime`, `inv_xtime`, SubWord/RotWord, InvShiftRows/InvSubBytes/InvMixColumns functions, Nr=10, state-encoding localparams.
- Sub-module `aes_key_step`: combinational, with input `dir` selecting forward KeyExp or InvKeyStep, plus `rk_in`, `rcon`, and `rk_out`. It is shared by KEYX and the inverse states and is reusable by the encryptor.
- The top holds the FSM, `cnt` (4-bit), `rcon` (8-bit), `st` (128-bit), `rk` (128-bit), and the output registers.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Expect plaintext 00112233445566778899aabbccddeeff with `done` exactly 21 cycles after start. Internal `rk` in ADDK must be 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32. Expect plaintext 3243f6a8885a308d313198a2e0370734.
- Back-to-back: C.1 then B, with `start` held high in the DONE cycle. Expect two `done` pulses 22 cycles apart, with correct plaintexts.
- Start and input changes mid-operation: pulse `start` with new inputs at cycle 5 of C.1. Expect it to be ignored, giving a single `done` with the C.1 result.
- Reset at cycle 15 of C.1: outputs are 0 immediately and no `done` occurs. A fresh C.1 afterwards passes.
- Loopback: encryptor output fed to this block for 100 random key/plaintext pairs. The recovered plaintext must equal the original.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared helpers: GF(2^8) arithmetic, S-boxes, inverse round
// transforms and state encoding for the sequential cipher blocks.
package aes_pkg;

    localparam int NR = 10;

    localparam logic KS_FWD = 1'b0;
    localparam logic KS_INV = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEYX  = 3'd1;
    localparam logic [2:0] ST_ADDK  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_FINAL = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_KEYX  = ST_KEYX,
        S_ADDK  = ST_ADDK,
        S_ROUND = ST_ROUND,
        S_FINAL = ST_FINAL,
        S_DONE  = ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [8:0] t;
        t = x[0] ? ({1'b0, x} ^ 9'h11B) : {1'b0, x};
        return t[8:1];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // byte i of the block is bits [127-8i -: 8]; i = row + 4*col
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r)&3)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0E) ^ gf_mul(a1, 8'h0B)
                             ^ gf_mul(a2, 8'h0D) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0E)
                             ^ gf_mul(a2, 8'h0B) ^ gf_mul(a3, 8'h0D);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0D) ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0E) ^ gf_mul(a3, 8'h0B);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0B) ^ gf_mul(a1, 8'h0D)
                             ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0E);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_decrypt_seq_if.sv
// Request/response bundle of the sequential AES decryptor.
// master drives requests, slave is the cipher core.
interface aes_decrypt_seq_if;
    import aes_pkg::*;

    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (
        output start, ciphertext, key,
        input  plaintext, done, busy
    );

    modport slave (
        input  start, ciphertext, key,
        output plaintext, done, busy
    );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key schedule step, forward (i -> i+1) or
// inverse (i -> i-1), selected by dir.
module aes_key_step
    import aes_pkg::*;
(
    input  logic         dir,
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0, i1, i2, i3;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    // both directions computed, dir picks the result
    always_comb begin
        f0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h0};
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        i3 = w3 ^ w2;
        i2 = w2 ^ w1;
        i1 = w1 ^ w0;
        i0 = w0 ^ sub_word(rot_word(i3)) ^ {rcon, 24'h0};
        rk_out = (dir == KS_INV) ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
    end

endmodule

// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 inverse cipher: forward key expansion to round
// key 10, then one inverse round per clock with backward key steps.
module aes_decrypt_seq
    import aes_pkg::*;
(
    input logic         clk,
    input logic         rst,
    aes_decrypt_seq_if.slave bus
);

    state_t       state, state_n;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] rk_nxt;
    logic [127:0] pt_q;
    logic         done_q;
    logic         busy_q;
    logic         ks_dir;

    assign ks_dir = (state == S_KEYX) ? KS_FWD : KS_INV;

    aes_key_step u_ks (
        .dir    (ks_dir),
        .rk_in  (rk),
        .rcon   (rcon),
        .rk_out (rk_nxt)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // next-state decode; start only matters in IDLE/DONE
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE: state_n = bus.start ? S_KEYX : S_IDLE;
            S_KEYX:  if (cnt == 4'(NR - 1)) state_n = S_ADDK;
            S_ADDK:  state_n = S_ROUND;
            S_ROUND: if (cnt == 4'(NR - 2)) state_n = S_FINAL;
            S_FINAL: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // block state, round key, rcon and round counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= '0;
            rk   <= '0;
            rcon <= '0;
            cnt  <= '0;
            pt_q <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        st   <= bus.ciphertext;
                        rk   <= bus.key;
                        rcon <= 8'h01;
                        cnt  <= '0;
                    end
                end
                S_KEYX: begin
                    rk <= rk_nxt;
                    if (cnt == 4'(NR - 1)) begin
                        rcon <= 8'h36;
                        cnt  <= '0;
                    end else begin
                        rcon <= xtime(rcon);
                        cnt  <= cnt + 4'd1;
                    end
                end
                S_ADDK: begin
                    st   <= st ^ rk;
                    rk   <= rk_nxt;
                    rcon <= inv_xtime(rcon);
                    cnt  <= '0;
                end
                S_ROUND: begin
                    st   <= inv_mix_columns(
                                inv_sub_bytes(inv_shift_rows(st)) ^ rk);
                    rk   <= rk_nxt;
                    rcon <= inv_xtime(rcon);
                    cnt  <= cnt + 4'd1;
                end
                S_FINAL: begin
                    pt_q <= inv_sub_bytes(inv_shift_rows(st)) ^ rk;
                end
                default: begin
                end
            endcase
        end
    end

    // registered status flags derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= (state_n == S_DONE);
            busy_q <= (state_n != S_IDLE) && (state_n != S_DONE);
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Scoreboard bench for aes_decrypt_seq with a table-driven AES model.
module tb_aes_decrypt_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0 = 0;

    aes_decrypt_seq_if bus();

    aes_decrypt_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t         q[$];
    logic [127:0] last_pt = '0;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];
    logic [7:0] isb[256];
    logic [7:0] ex [256];
    logic [7:0] lg [256];
    logic [7:0] ks [176];
    logic [7:0] s  [16];
    logic [7:0] tmp[16];
    logic [7:0] fw [16] = '{8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1,
                            8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd1, 8'd1, 8'd2};
    logic [7:0] iv [16] = '{8'd14, 8'd11, 8'd13, 8'd9, 8'd9, 8'd14, 8'd11, 8'd13,
                            8'd13, 8'd9, 8'd14, 8'd11, 8'd11, 8'd13, 8'd9, 8'd14};

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return ex[(int'(lg[a]) + int'(lg[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] inv;
        logic [7:0] y;
        logic [7:0] c63;
        c63 = 8'h63;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = v;
            lg[v] = 8'(i);
            v = v ^ {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        ex[255] = ex[0];
        lg[0] = 8'h00;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
            for (int b = 0; b < 8; b++) begin
                y[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
                     ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
            end
            sb[x] = y;
            isb[y] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [7:0] rc;
        logic [7:0] tw[4];
        int base, p;
        for (int i = 0; i < 16; i++) ks[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            base = 16 * r;
            p = base - 16;
            tw[0] = sb[ks[p+13]] ^ rc;
            tw[1] = sb[ks[p+14]];
            tw[2] = sb[ks[p+15]];
            tw[3] = sb[ks[p+12]];
            rc = gm(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    ks[base+4*c+i] = ks[p+4*c+i]
                        ^ ((c == 0) ? tw[i] : ks[base+4*(c-1)+i]);
        end
    endtask

    task automatic addk(input int r);
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*r+i];
    endtask

    task automatic sub(input bit inv);
        for (int i = 0; i < 16; i++) s[i] = inv ? isb[s[i]] : sb[s[i]];
    endtask

    task automatic shift(input bit inv);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                tmp[r+4*c] = inv ? s[r+4*((c-r+4)%4)] : s[r+4*((c+r)%4)];
        for (int i = 0; i < 16; i++) s[i] = tmp[i];
    endtask

    task automatic mix(input bit inv);
        logic [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gm(inv ? iv[4*i+j] : fw[4*i+j], s[j+4*c]);
                tmp[i+4*c] = acc;
            end
        for (int i = 0; i < 16; i++) s[i] = tmp[i];
    endtask

    task automatic load(input logic [127:0] b);
        for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8];
    endtask

    task automatic unload(output logic [127:0] b);
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = s[i];
    endtask

    task automatic ref_encrypt(input logic [127:0] k, input logic [127:0] p,
                               output logic [127:0] c);
        expand(k);
        load(p);
        addk(0);
        for (int r = 1; r < 10; r++) begin
            sub(0); shift(0); mix(0); addk(r);
        end
        sub(0); shift(0); addk(10);
        unload(c);
    endtask

    task automatic ref_decrypt(input logic [127:0] k, input logic [127:0] c,
                               output logic [127:0] p);
        expand(k);
        load(c);
        addk(10);
        for (int r = 9; r >= 1; r--) begin
            shift(1); sub(1); addk(r); mix(1);
        end
        shift(1); sub(1); addk(0);
        unload(p);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_pt = '0;
        end else if (bus.done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 want done=0 (pt %h)",
                         bus.plaintext);
            end else begin
                e = q.pop_front();
                chk("plaintext", bus.plaintext, e.pt);
                chk("done_cycle", 128'(cyc), 128'(e.due));
                chk("busy_at_done", 128'(bus.busy), 128'(0));
                last_pt = e.pt;
            end
        end else begin
            chk("pt_hold", bus.plaintext, last_pt);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 200) begin
            step();
            g++;
        end
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p);
        exp_t e;
        bus.key = k;
        bus.ciphertext = c;
        bus.start = 1'b1;
        t0 = cyc;
        e.pt = p;
        e.due = cyc + 22;
        q.push_back(e);
        step();
        bus.start = 1'b0;
        chk("busy_after_start", 128'(bus.busy), 128'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        step();
    endtask

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k, p, c;
        bus.start = 1'b0;
        bus.key = '0;
        bus.ciphertext = '0;
        build_tables();
        step();
        step();
        chk("reset_pt", bus.plaintext, 128'h0);
        chk("reset_done", 128'(bus.done), 128'(0));
        chk("reset_busy", 128'(bus.busy), 128'(0));
        rst = 1'b1;
        step();

        // FIPS-197 C.1 with round key 10 visible in ADDK
        issue(K_C1, C_C1, P_C1);
        wait_cyc(t0 + 11);
        chk("addk_rk", dut.rk, RK10);
        drain();

        // FIPS-197 appendix B
        issue(K_B, C_B, P_B);
        drain();

        // back-to-back: B accepted in the DONE cycle of C.1
        issue(K_C1, C_C1, P_C1);
        wait_cyc(t0 + 22);
        issue(K_B, C_B, P_B);
        drain();

        // start with new inputs mid-operation is ignored
        issue(K_C1, C_C1, P_C1);
        wait_cyc(t0 + 5);
        bus.start = 1'b1;
        bus.key = r128();
        bus.ciphertext = r128();
        step();
        bus.start = 1'b0;
        drain();

        // reset mid-operation aborts without done
        issue(K_C1, C_C1, P_C1);
        wait_cyc(t0 + 15);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_pt", bus.plaintext, 128'h0);
        chk("abort_done", 128'(bus.done), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        q.delete();
        step();
        step();
        rst = 1'b1;
        repeat (30) step();
        issue(K_C1, C_C1, P_C1);
        drain();

        // random ciphertexts against the reference inverse cipher
        for (int i = 0; i < 20; i++) begin
            k = r128();
            c = r128();
            ref_decrypt(k, c, p);
            issue(k, c, p);
            drain();
        end

        // loopback through the reference encryptor
        for (int i = 0; i < 100; i++) begin
            k = r128();
            p = r128();
            ref_encrypt(k, p, c);
            issue(k, c, p);
            drain();
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
